// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

    localparam int REG_W = 4;
    localparam logic [REG_W-1:0] ZERO_REG = 4'd0;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } hazard_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use bubbles, taken-branch
// flushes, data-memory freezes and a timeout halt with sticky error.
//
// state | meaning
// RUN   | pipeline advanced last cycle
// WAIT  | previous cycle was frozen on data memory
// HALT  | memory timeout; only reset leaves this state
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] IF_IDRs,
    input  logic [REG_W-1:0] IF_IDRt,
    input  logic             IF_IDUsesRt,
    input  logic [REG_W-1:0] ID_EXRt,
    input  logic             ID_EXMemRead,
    input  logic             EX_Taken,
    input  logic             EX_MEMMemReq,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IF_IDWrite,
    output logic             ID_EXBubble,
    output logic             IF_IDFlush,
    output logic             ID_EXFlush,
    output logic             EX_MEMHold,
    output logic             MEM_WBBubble,
    output logic             halt,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

    hazard_state_e   state_q, state_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_err_q, mem_err_d;

    logic load_use;
    logic frozen;
    logic stall_inc;
    logic flush_inc;

    assign load_use = ID_EXMemRead && (ID_EXRt != ZERO_REG) &&
                      ((ID_EXRt == IF_IDRs) || (IF_IDUsesRt && (ID_EXRt == IF_IDRt)));
    assign frozen   = EX_MEMMemReq && !dmem_ready;

    always_comb begin
        PCWrite      = 1'b1;
        IF_IDWrite   = 1'b1;
        ID_EXBubble  = 1'b0;
        IF_IDFlush   = 1'b0;
        ID_EXFlush   = 1'b0;
        EX_MEMHold   = 1'b0;
        MEM_WBBubble = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        state_d      = RUN;
        wait_cnt_d   = '0;
        mem_err_d    = mem_err_q;

        if (!rst_n) begin
            mem_err_d = 1'b0;
        end else if (state_q == HALT) begin
            PCWrite      = 1'b0;
            IF_IDWrite   = 1'b0;
            EX_MEMHold   = 1'b1;
            MEM_WBBubble = 1'b1;
            state_d      = HALT;
            wait_cnt_d   = wait_cnt_q;
        end else if (frozen) begin
            // Branch and load-use decisions wait until the pipeline moves again.
            PCWrite      = 1'b0;
            IF_IDWrite   = 1'b0;
            EX_MEMHold   = 1'b1;
            MEM_WBBubble = 1'b1;
            stall_inc    = 1'b1;
            wait_cnt_d   = wait_cnt_q + 1'b1;
            if (wait_cnt_q == WAIT_LAST) begin
                state_d   = HALT;
                mem_err_d = 1'b1;
            end else begin
                state_d = WAIT;
            end
        end else if (EX_Taken) begin
            // Any load-use consumer sits in IF/ID and is being flushed anyway.
            IF_IDFlush = 1'b1;
            ID_EXFlush = 1'b1;
            flush_inc  = 1'b1;
        end else if (load_use) begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            ID_EXBubble = 1'b1;
            stall_inc   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign halt    = (state_q == HALT);
    assign mem_err = mem_err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with short timeout and narrow counters.
module tb_hazard_ctrl;
    import pipe_pkg::*;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REG_W-1:0] IF_IDRs, IF_IDRt, ID_EXRt;
    logic             IF_IDUsesRt, ID_EXMemRead, EX_Taken, EX_MEMMemReq, dmem_ready;
    logic             PCWrite, IF_IDWrite, ID_EXBubble, IF_IDFlush, ID_EXFlush;
    logic             EX_MEMHold, MEM_WBBubble, halt, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IF_IDRs      (IF_IDRs),
        .IF_IDRt      (IF_IDRt),
        .IF_IDUsesRt  (IF_IDUsesRt),
        .ID_EXRt      (ID_EXRt),
        .ID_EXMemRead (ID_EXMemRead),
        .EX_Taken     (EX_Taken),
        .EX_MEMMemReq (EX_MEMMemReq),
        .dmem_ready   (dmem_ready),
        .PCWrite      (PCWrite),
        .IF_IDWrite   (IF_IDWrite),
        .ID_EXBubble  (ID_EXBubble),
        .IF_IDFlush   (IF_IDFlush),
        .ID_EXFlush   (ID_EXFlush),
        .EX_MEMHold   (EX_MEMHold),
        .MEM_WBBubble (MEM_WBBubble),
        .halt         (halt),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    // Advance one edge, then let outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        IF_IDRs = 4'd1; IF_IDRt = 4'd2; IF_IDUsesRt = 1'b0;
        ID_EXRt = 4'd0; ID_EXMemRead = 1'b0; EX_Taken = 1'b0;
        EX_MEMMemReq = 1'b0; dmem_ready = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        ID_EXMemRead = 1'b1; ID_EXRt = 4'd5; IF_IDRs = 4'd5;
        #1;
        n_checks++;
        if ({PCWrite, IF_IDWrite, ID_EXBubble} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 110", {PCWrite, IF_IDWrite, ID_EXBubble});
        end
        step();
        rst_n = 1'b1;
        set_idle();
        n_checks++;
        if ({halt, mem_err, stall_cnt, flush_cnt} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_state: halt=%b err=%b stall=%0d flush=%0d expected all 0",
                     halt, mem_err, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_load_use_rs();
        do_reset();
        ID_EXMemRead = 1'b1; ID_EXRt = 4'd5; IF_IDRs = 4'd5;
        #1;
        n_checks++;
        if ({PCWrite, IF_IDWrite, ID_EXBubble, IF_IDFlush} !== 4'b0010) begin
            n_fail++;
            $display("FAIL load_use_rs: got %b expected 0010",
                     {PCWrite, IF_IDWrite, ID_EXBubble, IF_IDFlush});
        end
        step();
        ID_EXMemRead = 1'b0; ID_EXRt = 4'd0;
        #1;
        n_checks++;
        if ({PCWrite, IF_IDWrite, ID_EXBubble} !== 3'b110) begin
            n_fail++;
            $display("FAIL load_use_one_cycle: got %b expected 110", {PCWrite, IF_IDWrite, ID_EXBubble});
        end
        n_checks++;
        if (stall_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL load_use_stall_cnt: got %0d expected 1", stall_cnt);
        end
    endtask

    task automatic test_no_stall();
        ID_EXMemRead = 1'b1; ID_EXRt = 4'd0; IF_IDRs = 4'd0;
        #1;
        n_checks++;
        if ({PCWrite, IF_IDWrite, ID_EXBubble} !== 3'b110) begin
            n_fail++;
            $display("FAIL no_stall_r0: got %b expected 110", {PCWrite, IF_IDWrite, ID_EXBubble});
        end
        step();
        ID_EXRt = 4'd7; IF_IDRs = 4'd3; IF_IDRt = 4'd7; IF_IDUsesRt = 1'b0;
        #1;
        n_checks++;
        if ({PCWrite, IF_IDWrite, ID_EXBubble} !== 3'b110) begin
            n_fail++;
            $display("FAIL no_stall_rt_unused: got %b expected 110", {PCWrite, IF_IDWrite, ID_EXBubble});
        end
        step();
        n_checks++;
        if (stall_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL no_stall_cnt: got %0d expected 1", stall_cnt);
        end
    endtask

    task automatic test_branch_load_use();
        do_reset();
        EX_Taken = 1'b1;
        ID_EXMemRead = 1'b1; ID_EXRt = 4'd3; IF_IDRs = 4'd9; IF_IDRt = 4'd3; IF_IDUsesRt = 1'b1;
        #1;
        n_checks++;
        if ({IF_IDFlush, ID_EXFlush, PCWrite, ID_EXBubble} !== 4'b1110) begin
            n_fail++;
            $display("FAIL branch_flush: got %b expected 1110",
                     {IF_IDFlush, ID_EXFlush, PCWrite, ID_EXBubble});
        end
        step();
        set_idle();
        n_checks++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL branch_counts: flush=%0d stall=%0d expected 1 and 0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        EX_MEMMemReq = 1'b1; dmem_ready = 1'b0; EX_Taken = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({PCWrite, IF_IDWrite, EX_MEMHold, MEM_WBBubble, IF_IDFlush, ID_EXFlush} !== 6'b001100) begin
                n_fail++;
                $display("FAIL mem_wait_frozen[%0d]: got %b expected 001100", i,
                         {PCWrite, IF_IDWrite, EX_MEMHold, MEM_WBBubble, IF_IDFlush, ID_EXFlush});
            end
            step();
        end
        dmem_ready = 1'b1;
        #1;
        n_checks++;
        if ({PCWrite, EX_MEMHold, MEM_WBBubble, IF_IDFlush, ID_EXFlush} !== 5'b10011) begin
            n_fail++;
            $display("FAIL mem_wait_release: got %b expected 10011",
                     {PCWrite, EX_MEMHold, MEM_WBBubble, IF_IDFlush, ID_EXFlush});
        end
        step();
        set_idle();
        n_checks++;
        if (stall_cnt !== 4'd3 || flush_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL mem_wait_counts: stall=%0d flush=%0d expected 3 and 1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        EX_MEMMemReq = 1'b1; dmem_ready = 1'b0;
        #1;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            n_checks++;
            if (halt !== 1'b0 || EX_MEMHold !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_pre[%0d]: halt=%b hold=%b expected 0 and 1", i, halt, EX_MEMHold);
            end
            step();
        end
        n_checks++;
        if ({halt, mem_err, PCWrite, IF_IDWrite, EX_MEMHold, MEM_WBBubble} !== 6'b110011) begin
            n_fail++;
            $display("FAIL timeout_halt: got %b expected 110011",
                     {halt, mem_err, PCWrite, IF_IDWrite, EX_MEMHold, MEM_WBBubble});
        end
        n_checks++;
        if (stall_cnt !== 4'd8) begin
            n_fail++;
            $display("FAIL timeout_stall_cnt: got %0d expected 8", stall_cnt);
        end
        dmem_ready = 1'b1; EX_MEMMemReq = 1'b0; EX_Taken = 1'b1;
        step();
        n_checks++;
        if ({halt, mem_err, PCWrite, IF_IDFlush} !== 4'b1100) begin
            n_fail++;
            $display("FAIL timeout_sticky: got %b expected 1100", {halt, mem_err, PCWrite, IF_IDFlush});
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({PCWrite, IF_IDWrite, IF_IDFlush, EX_MEMHold} !== 4'b1100) begin
            n_fail++;
            $display("FAIL timeout_reset_ctrl: got %b expected 1100",
                     {PCWrite, IF_IDWrite, IF_IDFlush, EX_MEMHold});
        end
        step();
        rst_n = 1'b1;
        set_idle();
        n_checks++;
        if ({halt, mem_err, PCWrite, stall_cnt} !== 7'b0010000) begin
            n_fail++;
            $display("FAIL timeout_cleared: halt=%b err=%b pcw=%b stall=%0d expected 0 0 1 0",
                     halt, mem_err, PCWrite, stall_cnt);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        do_reset();
        ID_EXMemRead = 1'b1; ID_EXRt = 4'd6; IF_IDRs = 4'd6;
        #1;
        for (int i = 1; i <= 20; i++) begin
            step();
            exp_cnt = (i > 15) ? 15 : i;
            n_checks++;
            if (stall_cnt !== exp_cnt[CNT_W-1:0]) begin
                n_fail++;
                $display("FAIL saturation[%0d]: got %0d expected %0d", i, stall_cnt, exp_cnt);
            end
        end
        set_idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        ID_EXMemRead = 1'b1; ID_EXRt = 4'd4; IF_IDRs = 4'd4;
        step();
        ID_EXMemRead = 1'b0; EX_Taken = 1'b1;
        step();
        EX_Taken = 1'b0; EX_MEMMemReq = 1'b1; dmem_ready = 1'b0;
        step();
        set_idle();
        n_checks++;
        if (stall_cnt !== 4'd2 || flush_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL back_to_back: stall=%0d flush=%0d expected 2 and 1", stall_cnt, flush_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_load_use_rs();
        test_no_stall();
        test_branch_load_use();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core. It is the stall-side counterpart of the EX-stage forwarding logic: it handles the hazards that bypassing cannot resolve.
- Load-use dependences: inserts one bubble.
- Taken branches/jumps resolved in EX: flushes the two younger instructions.
- Data-memory wait states: freezes the whole pipeline.
- Memory timeout: halts the core with a sticky error.

It sits beside the ID stage and drives the write enables and flush/bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Saturating performance counters record stall and flush cycles.

## Interface
- REG_W, 4, register-specifier width
- CNT_W, 16, performance-counter width
- MEM_TIMEOUT, 64, maximum consecutive frozen cycles before halt (≥2)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- IF_IDRs  in  REG_W  rs of instruction in ID
- IF_IDRt  in  REG_W  rt of instruction in ID
- IF_IDUsesRt  in  1  instruction in ID reads rt as a source
- ID_EXRt  in  REG_W  rt (load destination) of instruction in EX
- ID_EXMemRead  in  1  instruction in EX is a load
- EX_Taken  in  1  branch/jump taken, resolved in EX
- EX_MEMMemReq  in  1  instruction in MEM accesses data memory
- dmem_ready  in  1  data memory completes access this cycle
- PCWrite  out  1  PC update enable
- IF_IDWrite  out  1  IF/ID register enable
- ID_EXBubble  out  1  load zeroed controls into ID/EX
- IF_IDFlush  out  1  clear IF/ID to NOP
- ID_EXFlush  out  1  clear ID/EX to NOP
- EX_MEMHold  out  1  hold ID/EX and EX/MEM contents
- MEM_WBBubble  out  1  load NOP into MEM/WB
- halt  out  1  core halted
- mem_err  out  1  sticky timeout error
- stall_cnt  out  CNT_W  stall cycles, saturating
- flush_cnt  out  CNT_W  flush events, saturating

## Operation
- States: RUN, WAIT, HALT. WAIT means the previous cycle was frozen; wait_cnt counts consecutive frozen cycles.
- The control outputs are combinational from state and inputs. Counters, state and wait_cnt are registered.
- Priority: rst_n low > HALT > freeze > taken branch > load-use.
- Idle values: PCWrite=1, IF_IDWrite=1, all other control outputs 0.
- rst_n low:
  - Control outputs take idle values.
  - Next state is RUN; wait_cnt, stall_cnt, flush_cnt, halt and mem_err are cleared.
- HALT:
  - PCWrite=0, IF_IDWrite=0, EX_MEMHold=1, MEM_WBBubble=1, halt=1, mem_err=1.
  - HALT is exited only by reset. All other inputs are ignored.
- freeze (EX_MEMMemReq & !dmem_ready, state not HALT):
  - Outputs: PCWrite=0, IF_IDWrite=0, EX_MEMHold=1, MEM_WBBubble=1.
  - EX_Taken and load-use are suppressed; they re-evaluate once the pipeline advances.
  - stall_cnt increments, wait_cnt increments, next state WAIT.
  - If wait_cnt==MEM_TIMEOUT-1 in a frozen cycle, next state is HALT.
- Not frozen: wait_cnt clears and the next state is RUN.
- Taken branch (EX_Taken=1):
  - IF_IDFlush=1, ID_EXFlush=1, PCWrite=1 (PC loads the target).
  - flush_cnt increments. Any concurrent load-use is ignored, because its consumer is being flushed.
- Load-use:
  - Condition: ID_EXMemRead & ID_EXRt!=0 & (ID_EXRt==IF_IDRs | (IF_IDUsesRt & ID_EXRt==IF_IDRt)).
  - Outputs: PCWrite=0, IF_IDWrite=0, ID_EXBubble=1.
  - stall_cnt increments.
- Counters saturate at all-ones and never wrap.

## Timing
- Zero-latency control. Outputs reflect same-cycle inputs; the pipeline registers act on the next edge.
- Load-use stall is exactly one cycle. On the following cycle ID/EX holds the bubble, so the condition is false, and forwarding from MEM/WB supplies the loaded value.
- Freeze lasts exactly the number of cycles dmem_ready is low with EX_MEMMemReq high. It releases in the cycle dmem_ready rises.
- Timeout: HALT is entered after MEM_TIMEOUT consecutive frozen cycles. halt and mem_err are high from the next cycle.
- Counter increments are visible one cycle after the event.

## Structure
- Package pipe_pkg holds:
  - REG_W
  - ZERO_REG (4'd0)
  - the hazard-state enum {RUN, WAIT, HALT}
- Sub-module sat_counter (parameter W; ports clk, rst_n, inc, count) is instantiated twice.

## Test plan
- Load-use on rs: ID_EXMemRead=1, ID_EXRt=5, IF_IDRs=5.
  - Response: one cycle of PCWrite=0, IF_IDWrite=0, ID_EXBubble=1; stall_cnt 0→1.
- No stall cases: ID_EXRt=0 matching IF_IDRs=0; or rt match with IF_IDUsesRt=0.
  - Response: idle outputs; stall_cnt unchanged.
- Taken branch plus concurrent load-use on rt: EX_Taken=1 with load-use on rt.
  - Response: IF_IDFlush=ID_EXFlush=1, PCWrite=1, ID_EXBubble=0; flush_cnt=1; stall_cnt=0.
- Memory wait: EX_MEMMemReq=1, dmem_ready low for 3 cycles, EX_Taken=1 during the freeze.
  - Response: 3 frozen cycles with no flush; stall_cnt=3; release when ready rises, then the flush occurs.
- Timeout: MEM_TIMEOUT=8, dmem_ready held low.
  - Response: halt=1 and mem_err=1 after 8 frozen cycles.
  - Raising dmem_ready keeps the core halted; one cycle of rst_n=0 clears to RUN.
- Saturation: CNT_W=4, 20 consecutive load-use cycles.
  - Response: stall_cnt=15 and stays at 15.
